llc_bus_arbiter: RTL

- Arbitrates the LLC's shared system-bus port among three internal requesters: 0 = dirty-eviction writeback, 1 = miss fill (READ/RWIM), 2 = upgrade invalidate.
- Sequences each granted operation through three phases: issue handshake, snoop-result collection (with timeout and HITM retry), then a one-cycle response back to the requester.
- Maintains read/write/invalidate bus-traffic counters used by the statistics logic.
- Sits between the LLC miss/evict logic and the bus model.

---
 rtl/llc_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/llc_bus_arbiter.sv
// llc_bus_arbiter
//   Shares the LLC system-bus port among three requesters (0 = dirty-eviction
//   writeback, 1 = miss fill READ/RWIM, 2 = upgrade invalidate). Each granted
//   operation is issued on the bus, its snoop result is collected (with a
//   timeout and a bounded HITM retry for fills), and a one-cycle response is
//   returned. Read/write/invalidate traffic counters feed the statistics logic.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_op/req_addr       per-requester request (op: 001 READ,
//                                   010 WRITE, 011 INVALIDATE, 100 RWIM)
//   req_ready                       one-hot grant, combinational in IDLE
//   bus_valid/bus_op/bus_addr       bus issue, held until bus_ready
//   bus_cache_id                    constant CACHE_ID
//   bus_ready                       bus accepts the issued operation
//   snoop_valid/snoop_result        snoop strobe (00 NOHIT, 01 HIT, 10 HITM)
//   rsp_valid/rsp_id/rsp_snoop      one-cycle completion and its sideband,
//   rsp_timeout/rsp_err             sideband is zero when rsp_valid is low
//   rd_count/wr_count/inv_count     wrapping bus-traffic counters
module llc_bus_arbiter #(
    parameter logic [3:0]  CACHE_ID      = 4'd0,
    parameter int unsigned SNOOP_TIMEOUT = 16,
    parameter int unsigned MAX_RETRY     = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req_valid,
    input  logic [2:0][2:0]  req_op,
    input  logic [2:0][31:0] req_addr,
    output logic [2:0]       req_ready,
    output logic             bus_valid,
    output logic [2:0]       bus_op,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_cache_id,
    input  logic             bus_ready,
    input  logic             snoop_valid,
    input  logic [1:0]       snoop_result,
    output logic             rsp_valid,
    output logic [1:0]       rsp_id,
    output logic [1:0]       rsp_snoop,
    output logic             rsp_timeout,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] inv_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SNOOP, S_RESP} state_e;

    typedef enum logic [2:0] {
        OP_READ  = 3'b001,
        OP_WRITE = 3'b010,
        OP_INV   = 3'b011,
        OP_RWIM  = 3'b100
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10,
        SNP_RSVD  = 2'b11
    } snoop_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        retry_q, retry_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [1:0]        snoop_q, snoop_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  inv_q, inv_d;

    // Round-robin winner search
    logic [2:0]        grant;
    logic              win_ok;
    logic [1:0]        win_id;
    logic [2:0]        sum3;
    logic [1:0]        cand;
    logic [2:0]        win_op;
    logic              win_legal;
    logic              is_fill;

    always_comb begin
        grant  = '0;
        win_ok = 1'b0;
        win_id = '0;
        sum3   = '0;
        cand   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum3 = {1'b0, ptr_q} + 3'(i);
            cand = (sum3 >= 3'd3) ? 2'(sum3 - 3'd3) : sum3[1:0];
            if (!win_ok && req_valid[cand]) begin
                win_ok = 1'b1;
                win_id = cand;
            end
        end
        if (win_ok) begin
            grant[win_id] = 1'b1;
        end
    end

    assign win_op    = req_op[win_id];
    assign win_legal = win_op inside {OP_READ, OP_WRITE, OP_INV, OP_RWIM};
    assign is_fill   = (op_q == OP_READ) || (op_q == OP_RWIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        addr_d    = addr_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        snoop_d   = snoop_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        inv_d     = inv_q;

        case (state_q)
            S_IDLE: begin
                if (win_ok) begin
                    id_d      = win_id;
                    op_d      = win_op;
                    addr_d    = req_addr[win_id];
                    retry_d   = '0;
                    snoop_d   = SNP_NOHIT;
                    timeout_d = 1'b0;
                    ptr_d     = (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
                    if (win_legal) begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end

            S_ISSUE: begin
                if (bus_ready) begin
                    if (is_fill) begin
                        rd_d = rd_q + CNT_W'(1);
                    end else if (op_q == OP_WRITE) begin
                        wr_d = wr_q + CNT_W'(1);
                    end else begin
                        inv_d = inv_q + CNT_W'(1);
                    end
                    tmo_d   = '0;
                    state_d = S_SNOOP;
                end
            end

            S_SNOOP: begin
                tmo_d = tmo_q + 8'd1;
                if (snoop_valid) begin
                    if (snoop_result == SNP_HITM && is_fill &&
                        retry_q < 2'(MAX_RETRY)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_RESP;
                        if (snoop_result == SNP_RSVD) begin
                            snoop_d = SNP_NOHIT;
                            err_d   = 1'b1;
                        end else begin
                            snoop_d = snoop_result;
                        end
                    end
                // The decision is taken one cycle ahead so the response lands
                // exactly SNOOP_TIMEOUT cycles after the issue handshake.
                end else if (tmo_q == 8'(SNOOP_TIMEOUT - 2)) begin
                    timeout_d = 1'b1;
                    snoop_d   = SNP_NOHIT;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            snoop_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            inv_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            snoop_q   <= snoop_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            inv_q     <= inv_d;
        end
    end

    // Outputs decode from state so everything is zero while in reset.
    always_comb begin
        req_ready   = (state_q == S_IDLE) ? grant : '0;
        bus_valid   = (state_q == S_ISSUE);
        bus_op      = bus_valid ? op_q : '0;
        bus_addr    = bus_valid ? addr_q : '0;
        rsp_valid   = (state_q == S_RESP);
        rsp_id      = rsp_valid ? id_q : '0;
        rsp_snoop   = rsp_valid ? snoop_q : '0;
        rsp_timeout = rsp_valid & timeout_q;
        rsp_err     = rsp_valid & err_q;
    end

    assign bus_cache_id = CACHE_ID;
    assign rd_count     = rd_q;
    assign wr_count     = wr_q;
    assign inv_count    = inv_q;

endmodule
